// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared widths and types for the 4:1 mux data path
package mux_pkg;
  localparam int DATA_W = 4;
  localparam int NCH    = 4;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [1:0]        ch_t;
endpackage

// File: rtl/mux_4_1.sv
// rtl/mux_4_1.sv - combinational 4:1 data multiplexer
module mux_4_1
  import mux_pkg::*;
(
  input  data_t d0,
  input  data_t d1,
  input  data_t d2,
  input  data_t d3,
  input  ch_t   sel,
  output data_t y
);

  always_comb begin
    y = d0;
    unique case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/rr_mux_4_1_stage.sv
// rtl/rr_mux_4_1_stage.sv - round-robin 4-way merge with a one-entry registered output
module rr_mux_4_1_stage
  import mux_pkg::*;
#(
  parameter ch_t PTR_RESET = 2'd3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] in_valid,
  input  data_t          in_data0,
  input  data_t          in_data1,
  input  data_t          in_data2,
  input  data_t          in_data3,
  output logic [NCH-1:0] in_ready,
  output logic           out_valid,
  output data_t          out_data,
  output ch_t            out_sel,
  input  logic           out_ready
);

  // Returns {found, index}: first requester after 'last', wrapping back to 'last' itself.
  function automatic logic [2:0] rr_grant(input logic [NCH-1:0] req, input ch_t last);
    logic found;
    ch_t  gnt;
    ch_t  idx;
    found = 1'b0;
    gnt   = last;
    for (int k = 1; k <= NCH; k++) begin
      idx = last + ch_t'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
    return {found, gnt};
  endfunction

  logic  out_valid_q, out_valid_d;
  data_t out_data_q,  out_data_d;
  ch_t   out_sel_q,   out_sel_d;
  ch_t   last_q,      last_d;

  logic  load;
  logic  gnt_any;
  ch_t   gnt;
  data_t mux_y;

  assign load = ~out_valid_q | out_ready;
  assign {gnt_any, gnt} = rr_grant(in_valid, last_q);

  mux_4_1 u_mux (
    .d0  (in_data0),
    .d1  (in_data1),
    .d2  (in_data2),
    .d3  (in_data3),
    .sel (gnt),
    .y   (mux_y)
  );

  always_comb begin
    in_ready = '0;
    if (!rst && load && gnt_any) begin
      in_ready[gnt] = 1'b1;
    end
  end

  // Priority pointer moves only on a real transfer so idle cycles keep fairness intact.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    last_d      = last_q;
    if (load) begin
      if (gnt_any) begin
        out_valid_d = 1'b1;
        out_data_d  = mux_y;
        out_sel_d   = gnt;
        last_d      = gnt;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      last_q      <= PTR_RESET;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      last_q      <= last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_4_1_stage.sv
// tb/tb_rr_mux_4_1_stage.sv - randomized and directed checks of rr_mux_4_1_stage against a reference model
module tb_rr_mux_4_1_stage;

  logic       clk;
  logic       rst;
  logic [3:0] in_valid;
  logic [3:0] in_data0, in_data1, in_data2, in_data3;
  logic [3:0] in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic [1:0] out_sel;
  logic       out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: content of the output register and the last granted channel.
  bit         m_valid;
  logic [3:0] m_data;
  int         m_sel;
  int         m_last;

  logic [3:0] sb_q[4][$];
  int         wt[4];

  rr_mux_4_1_stage #(.PTR_RESET(2'd3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .in_data3  (in_data3),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 4'h0;
    m_sel   = 0;
    m_last  = 3;
    for (int c = 0; c < 4; c++) begin
      sb_q[c].delete();
      wt[c] = 0;
    end
  endtask

  // Called one time unit after a rising edge; returns one time unit after the next one.
  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic step(input logic [3:0] v, input logic [15:0] dd, input logic ordy,
                      output logic [3:0] acc);
    bit         load;
    int         g;
    int         c;
    logic [3:0] exp_rdy;
    in_valid  = v;
    in_data0  = dd[3:0];
    in_data1  = dd[7:4];
    in_data2  = dd[11:8];
    in_data3  = dd[15:12];
    out_ready = ordy;
    #3;
    load = !m_valid || ordy;
    g = -1;
    if (load) begin
      for (int k = 1; k <= 4; k++) begin
        c = (m_last + k) % 4;
        if (v[c] && g < 0) g = c;
      end
    end
    exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, m_valid);
    check("out_data", out_data, m_data);
    check("out_sel", out_sel, m_sel);
    if (m_valid && ordy) begin
      check("sb_pending", sb_q[m_sel].size(), 1);
      if (sb_q[m_sel].size() > 0) check("sb_data", out_data, sb_q[m_sel].pop_front());
    end
    if (g >= 0) begin
      sb_q[g].push_back(dd[g*4 +: 4]);
      for (int i = 0; i < 4; i++) begin
        if (i == g || !v[i]) wt[i] = 0;
        else wt[i]++;
        check("starve_le3", (wt[i] <= 3), 1);
      end
    end
    acc = exp_rdy;
    @(posedge clk);
    if (load) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = dd[g*4 +: 4];
        m_sel   = g;
        m_last  = g;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  logic [3:0]  acc;
  logic [3:0]  pv;
  logic [15:0] pd;
  logic [3:0]  exp_seq [5];
  int          exp_alt [4];

  initial begin
    rst = 1'b1;
    in_valid = 4'hF;
    in_data0 = 0; in_data1 = 0; in_data2 = 0; in_data3 = 0;
    out_ready = 1'b1;
    model_reset();
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 4'b0000);
    check("rst_out_data", out_data, 4'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // First beat from channel 2 after reset.
    step(4'b0000, 16'h0000, 1'b1, acc);
    step(4'b0100, 16'h0A00, 1'b1, acc);
    check("t1_acc", acc, 4'b0100);
    check("t1_data", out_data, 4'hA);
    check("t1_sel", out_sel, 2);
    step(4'b0000, 16'h0000, 1'b1, acc);

    // All four valid, full throughput, round-robin from channel 0.
    do_reset();
    exp_seq[0] = 4'h1; exp_seq[1] = 4'h2; exp_seq[2] = 4'h3; exp_seq[3] = 4'h4; exp_seq[4] = 4'h1;
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 16'h4321, 1'b1, acc);
      check("t2_data", out_data, exp_seq[i]);
    end

    // Stall with channels 1 and 3 waiting, then resume after channel 0.
    for (int i = 0; i < 3; i++) begin
      step(4'b1010, 16'h5060, 1'b0, acc);
      check("t3_stall_acc", acc, 4'b0000);
      check("t3_hold", out_data, 4'h1);
    end
    step(4'b1010, 16'h5060, 1'b1, acc);
    check("t3_resume_sel", out_sel, 1);
    check("t3_resume_data", out_data, 4'h6);

    // Channels 0 and 2 alternate once channel 2 has been granted.
    do_reset();
    step(4'b0100, 16'h0900, 1'b1, acc);
    exp_alt[0] = 0; exp_alt[1] = 2; exp_alt[2] = 0; exp_alt[3] = 2;
    for (int i = 0; i < 4; i++) begin
      step(4'b0101, 16'h0903, 1'b1, acc);
      check("t4_alt_sel", out_sel, exp_alt[i]);
    end

    // Asynchronous reset in the middle of a cycle while the register is full.
    #1 rst = 1'b1;
    #1;
    check("t5_async_valid", out_valid, 0);
    check("t5_async_data", out_data, 4'h0);
    check("t5_async_sel", out_sel, 0);
    check("t5_async_ready", in_ready, 4'b0000);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    step(4'b1111, 16'h8765, 1'b1, acc);
    check("t5_after_sel", out_sel, 0);

    // Random stress with producers holding beats until accepted.
    step(4'b0000, 16'h0000, 1'b1, acc);
    pv = 4'b0000;
    pd = 16'h0000;
    for (int n = 0; n < 2000; n++) begin
      for (int c = 0; c < 4; c++) begin
        if (!pv[c] && $urandom_range(0, 1) == 1) begin
          pv[c] = 1'b1;
          pd[c*4 +: 4] = 4'($urandom);
        end
      end
      step(pv, pd, ($urandom_range(0, 3) != 0), acc);
      pv = pv & ~acc;
    end
    for (int i = 0; i < 3; i++) step(4'b0000, 16'h0000, 1'b1, acc);
    for (int c = 0; c < 4; c++) check("sb_drained", sb_q[c].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
